// File: rtl/frec_divider_prog_if.sv
// rtl/frec_divider_prog_if.sv - control/status bundle for the programmable clock divider
//
// Purpose: groups the divider's control inputs and registered outputs so the
//          divider and its user connect through one port.
// Signals:
//   enable       count enable (held phase when 0)
//   div_value    requested divide value N, half-period = N+1 clocks
//   load         one-cycle request to capture div_value as pending
//   clock_out    divided 50 % duty clock
//   strobe       one-cycle pulse on each rising edge of clock_out
//   load_pending a captured value is waiting for the next falling toggle
//   load_ack     one-cycle pulse when the pending value becomes active
// Modports: master drives the controls, slave is the divider.
interface frec_divider_prog_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic [WIDTH-1:0] div_value;
  logic             load;
  logic             clock_out;
  logic             strobe;
  logic             load_pending;
  logic             load_ack;

  modport master (
    output enable, div_value, load,
    input  clock_out, strobe, load_pending, load_ack
  );

  modport slave (
    input  enable, div_value, load,
    output clock_out, strobe, load_pending, load_ack
  );
endinterface

// File: rtl/frec_divider_prog.sv
// rtl/frec_divider_prog.sv - programmable glitch-free 50 % duty clock divider
//
// Purpose: divides the system clock by 2*(N+1), producing clock_out and a
//          one-cycle strobe on each rising toggle. A new N is captured as
//          pending and only applied on the falling toggle of clock_out, so
//          every high/low phase of a period uses the same N.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   bus    frec_divider_prog_if.slave (enable, div_value, load in;
//          clock_out, strobe, load_pending, load_ack out, all registered)
module frec_divider_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 8
) (
  input  logic               clock,
  input  logic               reset,
  frec_divider_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] contador;
  logic [WIDTH-1:0] active_div;
  logic [WIDTH-1:0] pending_div;
  logic             pending_valid;
  logic             clock_out_q;
  logic             strobe_q;
  logic             load_ack_q;

  // Terminal count of the current phase while counting.
  logic terminal;
  // Pending value is transferred this cycle (falling toggle only).
  logic apply_now;

  always_comb begin
    terminal  = bus.enable && (contador == active_div);
    apply_now = terminal && clock_out_q && pending_valid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      contador    <= '0;
      clock_out_q <= 1'b0;
      strobe_q    <= 1'b0;
      load_ack_q  <= 1'b0;
      active_div  <= DIV_RESET;
    end else begin
      strobe_q   <= 1'b0;
      load_ack_q <= 1'b0;
      if (terminal) begin
        contador    <= '0;
        clock_out_q <= ~clock_out_q;
        if (!clock_out_q) begin
          strobe_q <= 1'b1;
        end
        if (apply_now) begin
          active_div <= pending_div;
          load_ack_q <= 1'b1;
        end
      end else if (bus.enable) begin
        contador <= contador + WIDTH'(1);
      end
    end
  end

  // Capture path: a load coinciding with an apply still wins the pending
  // slot; the apply above reads the pre-load pending_div via NBA semantics.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_div   <= DIV_RESET;
      pending_valid <= 1'b0;
    end else if (bus.load) begin
      pending_div   <= bus.div_value;
      pending_valid <= 1'b1;
    end else if (apply_now) begin
      pending_valid <= 1'b0;
    end
  end

  assign bus.clock_out    = clock_out_q;
  assign bus.strobe       = strobe_q;
  assign bus.load_ack     = load_ack_q;
  assign bus.load_pending = pending_valid;

endmodule

// File: tb/tb_frec_divider_prog.sv
// tb/tb_frec_divider_prog.sv - self-checking bench for frec_divider_prog
module tb_frec_divider_prog;

  logic clock = 1'b0;
  logic reset = 1'b1;

  frec_divider_prog_if #(.WIDTH(16)) bus();

  frec_divider_prog #(.WIDTH(16), .DEFAULT_DIV(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit checking    = 1'b0;

  // Event times (edge number after reset release) taken from the model.
  int strobe_q[$];
  int ack_q[$];
  int fall_q[$];

  // Behavioural model: phase length counted in enabled cycles.
  bit m_lvl, m_strobe, m_ack, m_pv, m_prev;
  int m_cnt, m_n, m_pn;

  always @(posedge clock) begin
    bit applied;
    if (reset) begin
      m_lvl = 0; m_cnt = 0; m_n = 8; m_pn = 8; m_pv = 0;
      m_strobe = 0; m_ack = 0;
    end else begin
      applied  = 0;
      m_strobe = 0;
      m_ack    = 0;
      if (bus.enable) begin
        m_cnt++;
        if (m_cnt == m_n + 1) begin
          m_cnt = 0;
          m_lvl = !m_lvl;
          if (m_lvl) m_strobe = 1;
          else if (m_pv) begin
            m_n = m_pn; m_ack = 1; applied = 1;
          end
        end
      end
      if (bus.load) begin
        m_pn = int'(bus.div_value); m_pv = 1;
      end else if (applied) m_pv = 0;
    end
    cyc <= reset ? 0 : cyc + 1;
  end

  always @(negedge clock) begin
    if (checking) begin
      vectors++;
      if ({bus.clock_out, bus.strobe, bus.load_pending, bus.load_ack} !==
          {m_lvl, m_strobe, m_pv, m_ack}) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got co=%b st=%b lp=%b ack=%b want co=%b st=%b lp=%b ack=%b",
                 cyc, bus.clock_out, bus.strobe, bus.load_pending, bus.load_ack,
                 m_lvl, m_strobe, m_pv, m_ack);
      end
      if (!reset) begin
        if (m_strobe) strobe_q.push_back(cyc);
        if (m_ack) ack_q.push_back(cyc);
        if (m_prev && !m_lvl) fall_q.push_back(cyc);
      end
      m_prev = m_lvl;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic run_until(input int k);
    while (cyc < k) @(negedge clock);
  endtask

  task automatic clear_events();
    strobe_q.delete(); ack_q.delete(); fall_q.delete();
    m_prev = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; bus.enable = 1; bus.load = 0; bus.div_value = '0;
    @(negedge clock);
    @(negedge clock);
    checking = 1;
    reset    = 0;
    clear_events();
  endtask

  // Present a load so that it is sampled on edge k.
  task automatic drive_load(input int k, input int val);
    run_until(k - 1);
    bus.div_value = 16'(val);
    bus.load      = 1;
    run_until(k);
    bus.load      = 0;
  endtask

  task automatic set_enable(input int k, input bit v);
    run_until(k - 1);
    bus.enable = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 1; bus.load = 0; bus.div_value = '0;

    // Default divide by 8: rise 9, fall 18, strobe every 18.
    do_reset();
    run_until(50);
    chk("def_strobe0", qat(strobe_q, 0), 9);
    chk("def_strobe1", qat(strobe_q, 1), 27);
    chk("def_strobe2", qat(strobe_q, 2), 45);
    chk("def_fall0",   qat(fall_q, 0), 18);
    chk("def_fall1",   qat(fall_q, 1), 36);

    // Mid-phase change, overwrite, coincident load.
    do_reset();
    drive_load(12, 3);
    drive_load(31, 5);
    drive_load(32, 2);
    drive_load(34, 7);
    chk("coinc_load_pending", int'(bus.load_pending), 1);
    run_until(60);
    chk("mid_ack0",    qat(ack_q, 0), 18);
    chk("mid_strobe1", qat(strobe_q, 1), 22);
    chk("mid_strobe2", qat(strobe_q, 2), 30);
    chk("ovw_ack1",    qat(ack_q, 1), 34);
    chk("ovw_strobe3", qat(strobe_q, 3), 37);
    chk("coinc_ack2",  qat(ack_q, 2), 40);
    chk("coinc_strobe4", qat(strobe_q, 4), 48);
    chk("coinc_fall4", qat(fall_q, 4), 56);

    // Enable gating in low phase, then across a would-be apply.
    do_reset();
    set_enable(20, 0);
    set_enable(25, 1);
    drive_load(35, 4);
    set_enable(38, 0);
    set_enable(43, 1);
    run_until(60);
    chk("en_strobe1", qat(strobe_q, 1), 32);
    chk("en_ack0",    qat(ack_q, 0), 46);
    chk("en_ack_cnt", ack_q.size(), 1);
    chk("en_strobe2", qat(strobe_q, 2), 51);
    chk("en_fall2",   qat(fall_q, 2), 56);

    // Reset mid-operation with a pending value and clock_out high.
    do_reset();
    drive_load(12, 3);
    run_until(13);
    chk("rst_pre_lp", int'(bus.load_pending), 1);
    chk("rst_pre_co", int'(bus.clock_out), 1);
    reset = 1;
    @(negedge clock);
    chk("rst_outputs", int'({bus.clock_out, bus.strobe, bus.load_pending, bus.load_ack}), 0);
    reset = 0;
    clear_events();
    run_until(30);
    chk("rst_strobe0", qat(strobe_q, 0), 9);
    chk("rst_fall0",   qat(fall_q, 0), 18);
    chk("rst_strobe1", qat(strobe_q, 1), 27);
    chk("rst_no_ack",  ack_q.size(), 0);

    // Minimum divide: clock/2 after the apply at 18.
    do_reset();
    drive_load(2, 0);
    run_until(28);
    chk("min_ack0",     qat(ack_q, 0), 18);
    chk("min_strobe1",  qat(strobe_q, 1), 19);
    chk("min_strobe_n", strobe_q.size(), 6);
    chk("min_strobe5",  qat(strobe_q, 5), 27);
    chk("min_fall2",    qat(fall_q, 2), 22);

    checking = 0;
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frec_divider_prog.md
# frec_divider_prog

Programmable, parametrised clock divider. It derives a 50 % duty-cycle low-frequency clock and a one-cycle sample strobe from the system clock. The divide value can be changed at run time without glitches: a new value takes effect only at a full-period boundary. It sits between the 50 MHz system clock and the sampling/ADC logic, replacing the fixed divide-by-18 stage, which gave Fs ≈ 40.3 kHz after the downstream /69 stage.

## Interface
Parameters:
- WIDTH, 16: width of the counter and of the divide value.
- DEFAULT_DIV, 8: divide value loaded at reset. Must fit in WIDTH bits.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count enable; when 0, the counter and clock_out hold.
- div_value  in  WIDTH  requested divide value N; half-period = N+1 clock cycles.
- load  in  1  one-cycle request to capture div_value as the pending value.
- clock_out  out  1  divided clock; period = 2·(N+1) cycles.
- strobe  out  1  one-cycle pulse in the cycle clock_out becomes 1.
- load_pending  out  1  a captured value is waiting to be applied.
- load_ack  out  1  one-cycle pulse in the cycle the pending value becomes active.

## Operation
- Internal registers: contador[WIDTH], active_div[WIDTH], pending_div[WIDTH], pending_valid.
- Reset (takes priority over everything, including mid-period and mid-pending):
  - contador=0, clock_out=0, strobe=0, load_ack=0, pending_valid=0.
  - active_div=DEFAULT_DIV; pending_div=DEFAULT_DIV.
- Counting, enable=1:
  - If contador==active_div (terminal count):
    - contador←0 and clock_out←~clock_out.
    - If clock_out was 0: strobe←1.
    - If clock_out was 1 and pending_valid=1: active_div←pending_div, pending_valid←0, load_ack←1.
  - Otherwise contador←contador+1.
- Counting, enable=0:
  - contador, clock_out and active_div hold; strobe=0; no apply takes place.
- Load:
  - load=1 sets pending_div←div_value and pending_valid←1, regardless of enable.
  - A second load before the value is applied overwrites pending_div. Last one wins.
  - A load in the same cycle as an apply: the apply uses the old pending_div. The new value is captured and pending_valid stays 1.
- Apply rule: a new value takes effect only at the falling toggle of clock_out. Every high and low phase therefore uses the same N, and no truncated periods occur.
- Width rules:
  - contador never exceeds active_div, because it is cleared at every terminal count. No wrap-around case exists.
  - N=0 gives clock/2. N=2^WIDTH−1 gives the maximum half-period of 2^WIDTH cycles.
- strobe and load_ack are registered and last exactly one cycle.
- load_pending = pending_valid (registered).

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- With enable held at 1 from reset release:
  - clock_out rises on the (N+1)-th rising edge after reset deassertion.
  - strobe is 1 in that same cycle.
- clock_out toggles every N+1 enabled cycles. strobe period = 2·(N+1) enabled cycles.
- load → load_pending=1 on the next edge.
- Apply latency: the first falling toggle of clock_out after capture. The worst case is just under 2·(N_old+1) enabled cycles.
- After an apply:
  - The next high phase starts N_new+1 cycles later.
  - load_ack coincides with clock_out falling to 0.
- Deasserting enable stretches the current phase by exactly the number of disabled cycles.

## Test plan
- Default: reset, enable=1, DEFAULT_DIV=8 → clock_out rises at cycle 9 and falls at cycle 18, period 18. strobe is high at cycles 9, 27, 45.
- Minimum divide: load div_value=0 → after load_ack, clock_out toggles every cycle and strobe pulses every 2 cycles.
- Mid-phase change: N=8; load N=3 while clock_out=1 → the remaining high phase keeps 9 cycles, load_ack occurs at the fall, and subsequent phases are 4 cycles each.
- Overwrite/coincident load: load 5 then 2 before apply → only 2 takes effect. A load of 7 in the apply cycle → load_pending remains 1 and 7 applies at the next fall.
- enable gating: drop enable for 5 cycles mid-low-phase → that phase lasts N+1+5 cycles, strobe stays 0 while enable is low, and there is no apply while disabled.
- Reset mid-operation: assert reset with pending_valid=1 and clock_out=1 → the next cycle shows all outputs 0, active_div=8 and the pending value discarded. The sequence restarts as in the default scenario.
